cpu_clock_gen: RTL and testbench

//  Generates the CPU-wide clock-enable strobe for the 8-bit CPU.

---
 rtl/cpu_clock_gen_pkg.sv | 13 +
 rtl/cpu_clock_gen_if.sv | 24 ++
 rtl/cpu_clock_gen_debounce.sv | 43 ++++
 rtl/cpu_clock_gen.sv | 88 ++++++++
 tb/tb_cpu_clock_gen.sv | 131 +++++++++++++
 5 files changed

// File: rtl/cpu_clock_gen_pkg.sv
// rtl/cpu_clock_gen_pkg.sv - shared types and defaults for the CPU clock-enable generator
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        MODE_RUN  = 2'd0,
        MODE_STEP = 2'd1,
        MODE_HALT = 2'd2
    } clk_mode_e;

    localparam int DEFAULT_DIV_WIDTH       = 24;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/cpu_clock_gen_if.sv
// rtl/cpu_clock_gen_if.sv - control-unit / board side signals of the CPU clock-enable generator
interface cpu_clock_gen_if #(
    parameter int DIV_WIDTH = 24
) ();

    logic                 clk_halt;
    logic                 manual_mode;
    logic                 step_btn;
    logic [DIV_WIDTH-1:0] div_sel;
    logic                 cpu_clk_en;
    logic                 cpu_clk_led;
    logic                 halted;

    modport master (
        output clk_halt, manual_mode, step_btn, div_sel,
        input  cpu_clk_en, cpu_clk_led, halted
    );

    modport slave (
        input  clk_halt, manual_mode, step_btn, div_sel,
        output cpu_clk_en, cpu_clk_led, halted
    );

endinterface

// File: rtl/cpu_clock_gen_debounce.sv
// rtl/cpu_clock_gen_debounce.sv - 2-flop synchroniser plus stability-counter debounce for a pushbutton
module button_debounce #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse
);

    localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            stable_cnt <= '0;
            clean_out  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw_in;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (sync2 == clean_out) begin
                stable_cnt <= '0;
            end else if (stable_cnt == LAST) begin
                clean_out  <= sync2;
                stable_cnt <= '0;
                rise_pulse <= sync2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_clock_gen.sv
// rtl/cpu_clock_gen.sv - CPU clock-enable strobe: free-run divider, debounced single step, sticky halt
module cpu_clock_gen
    import cpu_clk_pkg::*;
#(
    parameter int DIV_WIDTH       = DEFAULT_DIV_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst,
    cpu_clock_gen_if.slave  bus
);

    clk_mode_e            state;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 mode_sync1;
    logic                 manual_synced;
    logic                 step_clean;
    logic                 step_rise;
    logic                 fire;
    logic                 clk_en_q;
    logic                 led_q;
    logic                 halted_q;

    button_debounce #(
        .STABLE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (bus.step_btn),
        .clean_out  (step_clean),
        .rise_pulse (step_rise)
    );

    // A pending mode change blocks firing so the first cycle in the new mode starts clean.
    always_comb begin
        fire = 1'b0;
        case (state)
            MODE_RUN:  fire = !manual_synced && (div_cnt >= bus.div_sel);
            MODE_STEP: fire = manual_synced && step_rise && step_clean;
            default:   fire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= MODE_RUN;
            div_cnt       <= '0;
            mode_sync1    <= 1'b0;
            manual_synced <= 1'b0;
            clk_en_q      <= 1'b0;
            led_q         <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            mode_sync1    <= bus.manual_mode;
            manual_synced <= mode_sync1;
            clk_en_q      <= fire & ~bus.clk_halt & ~halted_q;
            if (clk_en_q) begin
                led_q <= ~led_q;
            end
            if (bus.clk_halt) begin
                halted_q <= 1'b1;
            end

            if (bus.clk_halt || state == MODE_HALT) begin
                state <= MODE_HALT;
            end else if (state == MODE_RUN) begin
                if (manual_synced) begin
                    state   <= MODE_STEP;
                    div_cnt <= '0;
                end else if (fire) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else begin
                div_cnt <= '0;
                if (!manual_synced) begin
                    state <= MODE_RUN;
                end
            end
        end
    end

    assign bus.cpu_clk_en  = clk_en_q;
    assign bus.cpu_clk_led = led_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb/tb_cpu_clock_gen.sv - self-checking bench for cpu_clock_gen (DIV_WIDTH=8, DEBOUNCE_CYCLES=4)
module tb_cpu_clock_gen;

    localparam int DW = 8;
    localparam int DB = 4;

    typedef struct packed {
        logic          r;
        logic          man;
        logic          btn;
        logic          hlt;
        logic [DW-1:0] div;
        logic          en;
        logic          halted;
    } vec_t;

    typedef struct packed {
        logic en;
        logic led;
        logic halted;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_clock_gen_if #(.DIV_WIDTH(DW)) bus ();

    cpu_clock_gen #(
        .DIV_WIDTH       (DW),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    logic led_m  = 1'b0;
    logic prev_en = 1'b0;

    function automatic vec_t mk(input logic r, man, btn, hlt, input logic [DW-1:0] div,
                                input logic en, h);
        vec_t v;
        v.r = r; v.man = man; v.btn = btn; v.hlt = hlt;
        v.div = div; v.en = en; v.halted = h;
        return v;
    endfunction

    // Append n rows; bit (i-1) of en_mask is the expected strobe after the i-th edge.
    task automatic add(input int n, input logic r, man, btn, hlt, input logic [DW-1:0] div,
                       input logic [31:0] en_mask, input logic h);
        for (int i = 0; i < n; i++) vecs.push_back(mk(r, man, btn, hlt, div, en_mask[i], h));
    endtask

    task automatic drive(input vec_t v, input string tag);
        exp_t e;
        exp_t act;
        rst             = v.r;
        bus.manual_mode = v.man;
        bus.step_btn    = v.btn;
        bus.clk_halt    = v.hlt;
        bus.div_sel     = v.div;
        if (v.r) led_m = 1'b0;
        else if (prev_en) led_m = ~led_m;
        prev_en = v.r ? 1'b0 : v.en;
        e.en = v.en; e.led = led_m; e.halted = v.halted;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc_no++;
        act = {bus.cpu_clk_en, bus.cpu_clk_led, bus.halted};
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: en/led/halted got %b%b%b expected %b%b%b",
                     tag, cyc_no, act.en, act.led, act.halted, e.en, e.led, e.halted);
        end
    endtask

    task automatic seq(input string tag, input logic r, man, btn, hlt, input logic [DW-1:0] div,
                       input int n, input logic [31:0] en_mask, input logic h);
        for (int i = 0; i < n; i++) drive(mk(r, man, btn, hlt, div, en_mask[i], h), tag);
    endtask

    initial begin
        // Reset, then free-run div_sel=3, div_sel=0, and a 9->2 change with counter at 5.
        add(3,  1, 0, 0, 0, 8'd3, 32'h0,   1'b0);
        add(12, 0, 0, 0, 0, 8'd3, 32'h888, 1'b0);
        add(4,  0, 0, 0, 0, 8'd0, 32'hF,   1'b0);
        add(5,  0, 0, 0, 0, 8'd9, 32'h0,   1'b0);
        add(1,  0, 0, 0, 0, 8'd2, 32'h1,   1'b0);
        add(6,  0, 0, 0, 0, 8'd2, 32'h24,  1'b0);
        for (int i = 0; i < vecs.size(); i++) drive(vecs[i], "table");

        // Single step: one strobe 7 cycles after a clean press, none for a 2-cycle glitch.
        seq("step_enter",   0, 1, 0, 0, 8'd200, 4,  32'h0,  1'b0);
        seq("step_press",   0, 1, 1, 0, 8'd200, 10, 32'h40, 1'b0);
        seq("step_release", 0, 1, 0, 0, 8'd200, 10, 32'h0,  1'b0);
        seq("step_glitch",  0, 1, 1, 0, 8'd200, 2,  32'h0,  1'b0);
        seq("step_quiet",   0, 1, 0, 0, 8'd200, 12, 32'h0,  1'b0);

        // Halt on a would-fire cycle, then sticky through clk_halt low and a step press.
        seq("run_div1",     0, 0, 0, 0, 8'd1, 9,  32'h150, 1'b0);
        seq("pre_halt",     0, 0, 0, 0, 8'd1, 1,  32'h0,   1'b0);
        seq("halt_fire",    0, 0, 0, 1, 8'd1, 1,  32'h0,   1'b1);
        seq("halt_hold",    0, 0, 0, 0, 8'd1, 6,  32'h0,   1'b1);
        seq("halt_press",   0, 1, 1, 0, 8'd1, 10, 32'h0,   1'b1);
        seq("halt_release", 0, 1, 0, 0, 8'd1, 8,  32'h0,   1'b1);

        // Reset while halted and mid-debounce, then free-run timing as after power-up.
        seq("mid_debounce", 0, 1, 1, 0, 8'd1, 3,  32'h0,  1'b1);
        seq("rst_mid",      1, 0, 1, 0, 8'd3, 1,  32'h0,  1'b0);
        seq("rst_hold",     1, 0, 0, 0, 8'd3, 2,  32'h0,  1'b0);
        seq("rerun",        0, 0, 0, 0, 8'd3, 8,  32'h88, 1'b0);

        // Mode toggle mid-count, and a step press while free-running is ignored.
        seq("toggle_step",  0, 1, 0, 0, 8'd3, 6,  32'h0,  1'b0);
        seq("toggle_back",  0, 0, 0, 0, 8'd3, 7,  32'h40, 1'b0);
        seq("run_btn",      0, 0, 1, 0, 8'd3, 8,  32'h88, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
